// File: rtl/sprite_blit_engine.sv
// Sprite blitter: walks a SPR_W x SPR_H sprite ROM in raster order and emits clipped,
// optionally mirrored / keyed / erased pixels to the VGA adapter with a start/done handshake.
module sprite_blit_engine #(
    parameter int              SCREEN_W  = 160,
    parameter int              SCREEN_H  = 120,
    parameter int              X_W       = 8,
    parameter int              Y_W       = 7,
    parameter int              SPR_W     = 40,
    parameter int              SPR_H     = 40,
    parameter int              ADDR_W    = 11,
    parameter int              COLOR_W   = 3,
    parameter logic [COLOR_W-1:0] KEY_COLOR = 3'b101
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [X_W-1:0]     xInit,
    input  logic [Y_W-1:0]     yInit,
    input  logic               mirror,
    input  logic               keyEn,
    input  logic               erase,
    input  logic [COLOR_W-1:0] romColor,
    output logic [ADDR_W-1:0]  romAddr,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    output logic [COLOR_W-1:0] color,
    output logic               plot,
    output logic               busy,
    output logic               done
);
    localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
    localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       col_q, col_d;
    logic [RW-1:0]       row_q, row_d;
    logic [ADDR_W-1:0]   rowBase_q, rowBase_d;
    logic [X_W-1:0]      xBase_q;
    logic [Y_W-1:0]      yBase_q;
    logic                mirror_q, keyEn_q, erase_q;
    logic                accept;

    logic                s1_vld_q;
    logic [X_W:0]        s1_px_q;
    logic [Y_W:0]        s1_py_q;

    logic [X_W-1:0]      x_q;
    logic [Y_W-1:0]      y_q;
    logic [COLOR_W-1:0]  color_q;
    logic                plot_q, busy_q, done_q;

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        rowBase_d = rowBase_q;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                // done_q still high means this is the completion cycle; start is ignored there
                if (start && !done_q) begin
                    accept    = 1'b1;
                    col_d     = '0;
                    row_d     = '0;
                    rowBase_d = '0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (col_q == CW'(SPR_W - 1)) begin
                    col_d     = '0;
                    row_d     = row_q + 1'b1;
                    rowBase_d = rowBase_q + ADDR_W'(SPR_W);
                    if (row_q == RW'(SPR_H - 1))
                        state_d = DRAIN;
                end else begin
                    col_d = col_q + 1'b1;
                end
            end
            DRAIN:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        romAddr = '0;
        if (state_q == ISSUE)
            romAddr = rowBase_q + (mirror_q ? (ADDR_W'(SPR_W - 1) - ADDR_W'(col_q))
                                            : ADDR_W'(col_q));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            rowBase_q <= '0;
            xBase_q   <= '0;
            yBase_q   <= '0;
            mirror_q  <= 1'b0;
            keyEn_q   <= 1'b0;
            erase_q   <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_px_q   <= '0;
            s1_py_q   <= '0;
            x_q       <= '0;
            y_q       <= '0;
            color_q   <= '0;
            plot_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            rowBase_q <= rowBase_d;
            if (accept) begin
                xBase_q  <= xInit;
                yBase_q  <= yInit;
                mirror_q <= mirror;
                keyEn_q  <= keyEn;
                erase_q  <= erase;
            end
            // Coordinates are one bit wider so off-screen pixels clip instead of wrapping
            s1_vld_q <= (state_q == ISSUE);
            s1_px_q  <= {1'b0, xBase_q} + (X_W+1)'(col_q);
            s1_py_q  <= {1'b0, yBase_q} + (Y_W+1)'(row_q);
            x_q      <= s1_px_q[X_W-1:0];
            y_q      <= s1_py_q[Y_W-1:0];
            color_q  <= erase_q ? '0 : romColor;
            plot_q   <= s1_vld_q
                        && (s1_px_q < (X_W+1)'(SCREEN_W))
                        && (s1_py_q < (Y_W+1)'(SCREEN_H))
                        && (erase_q || !keyEn_q || (romColor != KEY_COLOR));
            busy_q   <= (state_d != IDLE);
            done_q   <= (state_q == DONE);
        end
    end

    assign x     = x_q;
    assign y     = y_q;
    assign color = color_q;
    assign plot  = plot_q;
    assign busy  = busy_q;
    assign done  = done_q;
endmodule

// File: tb/tb_sprite_blit_engine.sv
// Randomised bench for sprite_blit_engine (4x3 sprite) against a raster-order pixel model.
module tb_sprite_blit_engine;
    localparam int SW = 4;
    localparam int SH = 3;
    localparam int N  = SW * SH;

    logic       clk = 1'b0;
    logic       reset, start, mirror, keyEn, erase;
    logic [7:0] xInit;
    logic [6:0] yInit;
    logic [2:0] romColor;
    logic [3:0] romAddr;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] color;
    logic       plot, busy, done;

    logic [2:0] rom [16];
    int checks = 0;
    int errors = 0;

    int ex_plot [N];
    int ex_x    [N];
    int ex_y    [N];
    int ex_c    [N];
    int nplot, fx, fy, fc, lx, ly, lc;

    always #5 clk = ~clk;

    always @(posedge clk) romColor <= rom[romAddr];

    sprite_blit_engine #(
        .SCREEN_W(160), .SCREEN_H(120), .X_W(8), .Y_W(7),
        .SPR_W(SW), .SPR_H(SH), .ADDR_W(4), .COLOR_W(3), .KEY_COLOR(3'b101)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .xInit(xInit), .yInit(yInit),
        .mirror(mirror), .keyEn(keyEn), .erase(erase), .romColor(romColor),
        .romAddr(romAddr), .x(x), .y(y), .color(color), .plot(plot),
        .busy(busy), .done(done)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Pixel i is the i-th raster position of the sprite footprint.
    task automatic build_model(input int x0, input int y0, input bit m, input bit k, input bit e);
        for (int r = 0; r < SH; r++)
            for (int c = 0; c < SW; c++) begin
                int i, a, cc, px, py;
                i  = r * SW + c;
                a  = r * SW + (m ? SW - 1 - c : c);
                cc = int'(rom[a]);
                px = x0 + c;
                py = y0 + r;
                ex_x[i]    = px % 256;
                ex_y[i]    = py % 128;
                ex_c[i]    = e ? 0 : cc;
                ex_plot[i] = (px < 160 && py < 120 && (e || !k || cc != 5)) ? 1 : 0;
            end
    endtask

    task automatic rom_addr_fill();
        for (int a = 0; a < 16; a++) rom[a] = 3'(a);
    endtask

    task automatic rom_rand_fill(input bit nonzero);
        for (int a = 0; a < 16; a++) rom[a] = nonzero ? 3'($urandom_range(1, 7)) : 3'($urandom);
    endtask

    task automatic blit(input int x0, input int y0, input bit m, input bit k, input bit e,
                        input bit poke);
        build_model(x0, y0, m, k, e);
        @(negedge clk);
        xInit = 8'(x0); yInit = 7'(y0); mirror = m; keyEn = k; erase = e; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        xInit = 8'($urandom); yInit = 7'($urandom);
        mirror = 1'($urandom); keyEn = 1'($urandom); erase = 1'($urandom);
        nplot = 0;
        for (int kc = 0; kc <= N + 2; kc++) begin
            int ep;
            @(negedge clk);
            ep = (kc >= 2 && kc <= N + 1) ? ex_plot[kc - 2] : 0;
            chk("plot", int'(plot), ep);
            chk("busy", int'(busy), (kc <= N + 1) ? 1 : 0);
            chk("done", int'(done), (kc == N + 2) ? 1 : 0);
            if (kc >= 2 && kc <= N + 1) begin
                chk("x", int'(x), ex_x[kc - 2]);
                chk("y", int'(y), ex_y[kc - 2]);
                chk("color", int'(color), ex_c[kc - 2]);
            end
            if (plot) begin
                if (nplot == 0) begin fx = int'(x); fy = int'(y); fc = int'(color); end
                lx = int'(x); ly = int'(y); lc = int'(color);
                nplot++;
            end
            if (poke) start = (kc == 4 || kc == N + 2);
        end
        if (poke) begin
            @(negedge clk);
            start = 1'b0;
            chk("idle_busy_after_done", int'(busy), 0);
            @(negedge clk);
            chk("idle_busy2", int'(busy), 0);
            chk("idle_plot", int'(plot), 0);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; xInit = '0; yInit = '0;
        mirror = 1'b0; keyEn = 1'b0; erase = 1'b0;
        rom_addr_fill();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_romAddr", int'(romAddr), 0);
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_color", int'(color), 0);
        chk("rst_plot", int'(plot), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        reset = 1'b0;

        blit(10, 20, 0, 0, 0, 0);
        chk("t1_count", nplot, 12);
        chk("t1_first_x", fx, 10); chk("t1_first_y", fy, 20); chk("t1_first_c", fc, 0);
        chk("t1_last_x", lx, 13);  chk("t1_last_y", ly, 22);  chk("t1_last_c", lc, 3);

        blit(10, 20, 1, 0, 0, 0);
        chk("t2_first_c", fc, 3);
        chk("t2_last_c", lc, 0);

        blit(10, 20, 0, 1, 0, 0);
        chk("t3_count", nplot, 11);

        blit(158, 118, 0, 0, 0, 0);
        chk("t4_count", nplot, 4);
        chk("t4_first_x", fx, 158); chk("t4_first_y", fy, 118);
        chk("t4_last_x", lx, 159);  chk("t4_last_y", ly, 119);

        rom_rand_fill(1'b1);
        blit(30, 40, 1, 1, 1, 0);
        chk("t5_count", nplot, 12);
        chk("t5_first_c", fc, 0);
        chk("t5_last_c", lc, 0);

        // Reset in the middle of a blit
        rom_addr_fill();
        @(negedge clk);
        xInit = 8'd50; yInit = 7'd50; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_plot", int'(plot), 0);
        chk("rst_mid_busy", int'(busy), 0);
        chk("rst_mid_done", int'(done), 0);
        chk("rst_mid_addr", int'(romAddr), 0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("post_rst_done", int'(done), 0);
            chk("post_rst_plot", int'(plot), 0);
        end

        blit(10, 20, 0, 0, 0, 1);
        chk("fresh_count", nplot, 12);

        for (int t = 0; t < 30; t++) begin
            int x0, y0;
            rom_rand_fill(1'b0);
            x0 = ($urandom % 2 == 0) ? int'($urandom_range(150, 255)) : int'($urandom_range(0, 255));
            y0 = ($urandom % 2 == 0) ? int'($urandom_range(110, 127)) : int'($urandom_range(0, 127));
            blit(x0, y0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sprite_blit_engine.md
Name: sprite_blit_engine

Overview:
- Parametrised successor to the game datapath's hard-wired x/y counters and sprite address counter.
- Draws one WxH sprite from a synchronous sprite ROM to the VGA adapter at a latched origin (xInit, yInit).
- Supports horizontal mirroring (replaces separate left/right sprite ROMs), transparency keying, erase-to-black and screen-edge clipping.
- Sits between the game FSM (start/done handshake) and the VGA adapter (x, y, color, plot).

Parameters:
- SCREEN_W, 160, visible columns.
- SCREEN_H, 120, visible rows.
- X_W, 8, x coordinate width.
- Y_W, 7, y coordinate width.
- SPR_W, 40, sprite width in pixels.
- SPR_H, 40, sprite height in pixels.
- ADDR_W, 11, ROM address width; must satisfy 2^ADDR_W >= SPR_W*SPR_H.
- COLOR_W, 3, pixel colour width.
- KEY_COLOR, 3'b101, transparent colour value.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- start  in  1  begin a blit; sampled only in IDLE.
- xInit  in  X_W  sprite origin column.
- yInit  in  Y_W  sprite origin row.
- mirror  in  1  1 = horizontal flip.
- keyEn  in  1  1 = pixels equal to KEY_COLOR are not plotted.
- erase  in  1  1 = plot black over the full (clipped) footprint; ROM data ignored.
- romColor  in  COLOR_W  ROM q, valid 1 cycle after romAddr.
- romAddr  out  ADDR_W  ROM address.
- x  out  X_W  VGA x.
- y  out  Y_W  VGA y.
- color  out  COLOR_W  VGA colour.
- plot  out  1  VGA write enable.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset: state IDLE; romAddr, x, y, color = 0; plot, busy, done = 0; all counters 0. Reset mid-blit aborts immediately; no further plot pulses and no done pulse.
- States: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
- IDLE:
  - On start=1, latch xInit, yInit, mirror, keyEn, erase; clear col and row; go to ISSUE.
- ISSUE:
  - Each cycle drives romAddr = rowBase + (mirror ? SPR_W-1-col : col), where rowBase = row*SPR_W is kept as a running accumulator (no multiplier).
  - col increments each cycle. At col=SPR_W-1: col -> 0, row increments, rowBase += SPR_W.
  - At the last pixel (col=SPR_W-1, row=SPR_H-1), go to DRAIN.
  - Exactly SPR_W*SPR_H issue cycles.
- Stage 1 pipeline register (valid, px, py) aligns the coordinates with the 1-cycle ROM latency:
  - px = xBase+col and py = yBase+row, computed at X_W+1 and Y_W+1 bits.
  - Registered outputs: x = px[X_W-1:0], y = py[Y_W-1:0].
  - color = erase ? 0 : romColor.
  - plot = valid & (px < SCREEN_W) & (py < SCREEN_H) & (erase | ~keyEn | romColor != KEY_COLOR).
- DRAIN: one cycle, lets the final pixel reach the outputs. Then DONE.
- DONE: done=1 for exactly one cycle, busy=0 in the same cycle; return to IDLE.
- Latency:
  - First plot-eligible output appears 2 cycles after the start sample edge.
  - done asserts SPR_W*SPR_H+2 cycles after the start-accept edge.
- start while busy or in DONE is ignored. It is not queued.
- start asserted the cycle after done is accepted normally (back-to-back blits).
- Clipping: pixels with px >= SCREEN_W or py >= SCREEN_H are still stepped through and take the same time, but plot=0. Wrap-around never writes to the screen.
- Input changes to xInit, yInit, mirror, keyEn or erase during a blit have no effect until the next accepted start.
- plot is 0 in IDLE, DRAIN-output-complete cycles and DONE.

Test Plan:
- SPR_W=4, SPR_H=3; ROM = address; start with xInit=10, yInit=20, mirror=0, keyEn=0 -> 12 plots, (x,y,color) in raster order: (10,20,0), (11,20,1) ... (13,22,3 mod 8); done at cycle 14 after accept.
- Same setup with mirror=1 -> row 0 addresses 3,2,1,0; pixel (10,20) has color 3; row 1 starts at address 7.
- keyEn=1, KEY_COLOR=5, ROM = address -> the pixel from address 5 has plot=0; the other 11 plot; done timing unchanged.
- xInit=158, yInit=118, SPR 4x3 -> only columns 158-159 and rows 118-119 plot (4 pixels); no plot at x=0 or y=0 from wrap.
- erase=1 with a non-zero ROM -> all 12 in-bounds pixels plot with color=0.
- Reset asserted at cycle 5 of a blit -> plot=0 from the next cycle, no done pulse, busy=0. A fresh start then completes normally. A start pulsed while busy produces no second blit.
